// File: rtl/lpc_sniffer_pkg.sv
// ============================================================================
// lpc_sniffer_pkg : UART framing constants and word-FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package lpc_sniffer_pkg;

  localparam logic START_BIT            = 1'b0;
  localparam logic STOP_BIT             = 1'b1;
  localparam int   DATA_BITS            = 8;
  localparam int   CLKS_PER_BIT_DEFAULT = 104;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// uart_tx_byte : 8N1 byte serialiser with registered tx and one-cycle done
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_byte
  import lpc_sniffer_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       ready
);

  localparam int             BW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(DATA_BITS + 1);

  logic          active;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud;
  logic [7:0]    sh;
  logic          bit_end;
  logic          bit_val;
  logic [2:0]    data_idx;

  assign bit_end  = active && (baud == BAUD_LAST);
  assign done     = bit_end && (bit_cnt == LAST_BIT);
  assign ready    = !active;
  assign data_idx = 3'(bit_cnt - 4'd1);

  always_comb begin
    bit_val = STOP_BIT;
    if (bit_cnt == 4'd0)
      bit_val = START_BIT;
    else if (bit_cnt != LAST_BIT)
      bit_val = sh[data_idx];
  end

  // tx is registered from the bit state, so the line lags the counters by one clock
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      bit_cnt <= 4'd0;
      baud    <= '0;
      sh      <= 8'd0;
      tx      <= STOP_BIT;
    end else begin
      tx <= active ? bit_val : STOP_BIT;
      if (start && !active) begin
        active  <= 1'b1;
        bit_cnt <= 4'd0;
        baud    <= '0;
        sh      <= data;
      end else if (active) begin
        if (bit_end) begin
          baud <= '0;
          if (bit_cnt == LAST_BIT)
            active <= 1'b0;
          else
            bit_cnt <= bit_cnt + 4'd1;
        end else begin
          baud <= baud + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lpc_uart_tx.sv
// ============================================================================
// lpc_uart_tx : word FIFO plus MSB-byte-first word splitter feeding an 8N1 UART
// Rev 1.0
// ============================================================================
`default_nettype none

module lpc_uart_tx
  import lpc_sniffer_pkg::*;
#(
  parameter int AW           = 48,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AW-1:0]              in_data,
  input  logic                       in_enable,
  output logic                       tx,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int NB = AW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam int CW = $clog2(NB + 1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;

  logic [1:0]    state;
  logic [AW-1:0] shreg;
  logic [CW-1:0] byte_cnt;
  logic          ser_start;
  logic          ser_done;
  logic          ser_ready;

  assign full      = (fill == FW'(DEPTH));
  assign push      = in_enable && !full;
  assign pop       = (state == ST_IDLE) && (fill != '0);
  assign busy      = (state != ST_IDLE) || (fill != '0);
  assign ser_start = (state == ST_START) && ser_ready;

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wr_ptr] <= in_data;
  end

  // a strobe into a full FIFO is dropped even if a pop frees a slot this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (in_enable && full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_cnt <= CW'(NB);
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (ser_ready)
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ser_done) begin
            shreg    <= shreg << 8;
            byte_cnt <= byte_cnt - 1'b1;
            state    <= (byte_cnt == CW'(1)) ? ST_IDLE : ST_START;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (ser_start),
    .data  (shreg[AW-1 -: 8]),
    .tx    (tx),
    .done  (ser_done),
    .ready (ser_ready)
  );

endmodule

`default_nettype wire

// File: tb/tb_lpc_uart_tx.sv
// ============================================================================
// tb_lpc_uart_tx : randomized bench against a timing/queue reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lpc_uart_tx;

  localparam int AW     = 16;
  localparam int DEPTH  = 4;
  localparam int CPB    = 4;
  localparam int NB     = AW / 8;
  localparam int FW     = $clog2(DEPTH) + 1;
  localparam int BYTE_T = 10 * CPB + 1;   // start-to-start spacing inside one word
  localparam int WORD_T = NB * BYTE_T;    // cycles the word engine is out of IDLE

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_enable = 1'b0;
  logic [AW-1:0] in_data = '0;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [FW-1:0] fill;

  always #5 clk = ~clk;

  lpc_uart_tx #(
    .AW           (AW),
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_enable (in_enable),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .fill      (fill)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: accepted words queue; the engine takes the head word when
  // free and then owns the line for WORD_T cycles, next pop one cycle later.
  logic [AW-1:0] mq[$];
  logic [AW-1:0] cur_word;
  bit            m_ovf     = 1'b0;
  bit            have_word = 1'b0;
  bit            chk_en    = 1'b0;
  int            pop_edge  = 0;
  int            next_pop  = 0;
  int            max_fill  = 0;

  always @(posedge clk) begin : model
    int pre;
    cyc++;
    if (reset) begin
      mq.delete();
      m_ovf     = 1'b0;
      have_word = 1'b0;
      next_pop  = cyc + 1;
      chk_en    = 1'b1;
    end else begin
      pre = mq.size();
      if (in_enable) begin
        if (pre == DEPTH) m_ovf = 1'b1;
        else mq.push_back(in_data);
      end
      if (cyc >= next_pop && pre > 0) begin
        cur_word  = mq.pop_front();
        have_word = 1'b1;
        pop_edge  = cyc;
        next_pop  = cyc + WORD_T + 1;
      end
    end
  end

  function automatic logic exp_tx();
    int rel, k, b;
    logic [AW-1:0] w;
    logic [7:0] by;
    if (!have_word) return 1'b1;
    rel = cyc - (pop_edge + 2);
    if (rel < 0) return 1'b1;
    k = rel / BYTE_T;
    if (k >= NB) return 1'b1;
    b  = (rel % BYTE_T) / CPB;
    w  = cur_word >> (8 * (NB - 1 - k));
    by = w[7:0];
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    return (mq.size() > 0) || (have_word && (cyc - pop_edge) < WORD_T);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", 64'(tx), 64'(exp_tx()));
      check("busy", 64'(busy), 64'(exp_busy()));
      check("fill", 64'(fill), 64'(mq.size()));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (int'(fill) > max_fill) max_fill = int'(fill);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [AW-1:0] d);
    in_data   = d;
    in_enable = 1'b1;
    tick();
    in_enable = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000; i++) begin
      if (mq.size() == 0 && (!have_word || (cyc - pop_edge) > WORD_T + 2)) return;
      tick();
    end
    check("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int lat;
    bit found;

    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (50) tick();

    // single word: latency from strobe to start bit
    in_data   = 16'hA55A;
    in_enable = 1'b1;
    tick();
    in_enable = 1'b0;
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
    wait_drain();
    check("busy_after_word", 64'(busy), 64'd0);

    // overflow: one word in flight, then five back-to-back strobes
    max_fill = 0;
    strobe(16'h1111);
    repeat (5) tick();
    for (int i = 1; i <= 5; i++) strobe({2{8'(i)}});
    wait_drain();
    check("overflow_sticky", 64'(overflow), 64'd1);
    check("fill_peak", 64'(max_fill), 64'(DEPTH));

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // push on the same edge as a pop with fill == 2
    strobe(16'h2222);
    repeat (3) tick();
    strobe(16'h3333);
    strobe(16'h4444);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (next_pop == cyc + 1) found = 1'b1;
      else tick();
    end
    check("pop_edge_found", 64'(found), 64'd1);
    strobe(16'h5555);
    check("fill_push_pop", 64'(fill), 64'd2);
    wait_drain();

    // reset part-way through the second byte
    strobe(16'hC33C);
    repeat (2 + BYTE_T + 15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_fill", 64'(fill), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    strobe(16'h9A6B);
    wait_drain();

    // pointer wrap: slower than the drain rate
    for (int i = 0; i < 3 * DEPTH; i++) begin
      strobe(AW'($urandom));
      repeat ($urandom_range(WORD_T + 2, WORD_T + 30)) tick();
    end
    wait_drain();
    check("wrap_no_ovf", 64'(overflow), 64'd0);

    // random bursts, may overflow
    for (int i = 0; i < 40; i++) begin
      strobe(AW'($urandom));
      repeat ($urandom_range(0, 40)) tick();
    end
    wait_drain();
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
